// File: rtl/cic_readout_sequencer.sv
// Captures the two CIC decimator outputs into holding registers and streams them as tagged,
// round-robin arbitrated byte frames. Define CIC_READOUT_CHECKSUM_EN for a trailing XOR byte.
module cic_readout_sequencer #(
   parameter int W1 = 10,
   parameter int W2 = 20
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [W1-1:0] s1_data_i,
   input  logic          s1_strobe_i,
   input  logic [W2-1:0] s2_data_i,
   input  logic          s2_strobe_i,
   input  logic [1:0]    enable_i,
   input  logic          ovf_clr_i,
   output logic [7:0]    out_data_o,
   output logic          out_valid_o,
   output logic          out_last_o,
   input  logic          out_ready_i,
   output logic [1:0]    ovf_o,
   output logic          busy_o
);
   localparam int P1 = (W1 + 7) / 8;
   localparam int P2 = (W2 + 7) / 8;
   localparam int PM = (P1 > P2) ? P1 : P2;
   localparam int SW = 8 * (PM + 1);
`ifdef CIC_READOUT_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam logic [5:0] LEN1     = 6'(1 + P1 + CK);
   localparam logic [5:0] LEN2     = 6'(1 + P2 + CK);
   localparam logic [5:0] LAST_PAY = 6'(1 + CK);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2,
      ST_CHK  = 2'd3
   } state_t;

   state_t        state_r, state_next_s;
   logic [W1-1:0] hold1_r;
   logic [W2-1:0] hold2_r;
   logic [1:0]    pend_r, pend_next_s, lost_r, ovf_r, ovf_set_s;
   logic [1:0]    cap_s, gnt_mask_s, eff_pend_s;
   logic [2:0]    seq1_r, seq2_r;
   logic          last_ch_r, cur_ch_r;
   logic [SW-1:0] sh_r, sh_shift_s, frame_s;
   logic [5:0]    rem_r;
   logic [7:0]    hdr_s;
   logic          out_valid_r, out_last_r, busy_r;
   logic          hs_s, frame_end_s, grant_s, grant_ch_s;
`ifdef CIC_READOUT_CHECKSUM_EN
   logic [7:0]    csum_r;
`endif

   function automatic logic [7:0] header_byte(input logic ch, input logic [2:0] seq,
                                              input logic lost, input logic [2:0] cnt);
      return {ch, seq, lost, cnt};
   endfunction

   // Arbitration, capture/overflow decode and next frame image.
   always_comb begin
      hs_s        = out_valid_r & out_ready_i;
      frame_end_s = hs_s & out_last_r;
      eff_pend_s  = pend_r & enable_i;
      grant_s     = ((state_r == ST_IDLE) | frame_end_s) & (|eff_pend_s);
      grant_ch_s  = (&eff_pend_s) ? ~last_ch_r : eff_pend_s[1];
      if (grant_s) begin
         gnt_mask_s = grant_ch_s ? 2'b10 : 2'b01;
      end else begin
         gnt_mask_s = 2'b00;
      end
      cap_s       = {s2_strobe_i, s1_strobe_i} & enable_i;
      ovf_set_s   = cap_s & pend_r & ~gnt_mask_s;
      pend_next_s = enable_i & (cap_s | (pend_r & ~gnt_mask_s));
      if (grant_ch_s) begin
         hdr_s   = header_byte(1'b1, seq2_r, lost_r[1], 3'(P2));
         frame_s = {hdr_s, {(8*PM){1'b0}}} | (SW'(hold2_r) << (8 * (PM - P2)));
      end else begin
         hdr_s   = header_byte(1'b0, seq1_r, lost_r[0], 3'(P1));
         frame_s = {hdr_s, {(8*PM){1'b0}}} | (SW'(hold1_r) << (8 * (PM - P1)));
      end
      sh_shift_s = sh_r << 8;
`ifdef CIC_READOUT_CHECKSUM_EN
      if (rem_r == 6'd2) begin
         sh_shift_s[SW-1 -: 8] = csum_r;
      end else begin
         sh_shift_s[SW-1 -: 8] = sh_r[SW-9 -: 8];
      end
`endif
   end

   // Frame sequencing FSM next state.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: state_next_s = grant_s ? ST_HDR : ST_IDLE;
         ST_HDR:  state_next_s = hs_s ? ST_PAY : ST_HDR;
         ST_PAY: begin
            if (hs_s && (rem_r == LAST_PAY)) begin
`ifdef CIC_READOUT_CHECKSUM_EN
               state_next_s = ST_CHK;
`else
               state_next_s = grant_s ? ST_HDR : ST_IDLE;
`endif
            end else begin
               state_next_s = ST_PAY;
            end
         end
         ST_CHK:  state_next_s = hs_s ? (grant_s ? ST_HDR : ST_IDLE) : ST_CHK;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Holding registers, flags, counters and the outgoing byte shifter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold1_r     <= {W1{1'b0}};
         hold2_r     <= {W2{1'b0}};
         pend_r      <= 2'b00;
         lost_r      <= 2'b00;
         ovf_r       <= 2'b00;
         seq1_r      <= 3'd0;
         seq2_r      <= 3'd0;
         last_ch_r   <= 1'b1;
         cur_ch_r    <= 1'b0;
         sh_r        <= {SW{1'b0}};
         rem_r       <= 6'd0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
`ifdef CIC_READOUT_CHECKSUM_EN
         csum_r      <= 8'd0;
`endif
      end else begin
         if (cap_s[0]) hold1_r <= s1_data_i; else hold1_r <= hold1_r;
         if (cap_s[1]) hold2_r <= s2_data_i; else hold2_r <= hold2_r;
         pend_r <= pend_next_s;
         lost_r <= (lost_r & ~gnt_mask_s) | ovf_set_s;
         ovf_r  <= (ovf_clr_i ? 2'b00 : ovf_r) | ovf_set_s;
         busy_r <= (state_next_s != ST_IDLE);
         if ((state_r == ST_HDR) && hs_s) begin
            if (cur_ch_r) seq2_r <= seq2_r + 3'd1; else seq1_r <= seq1_r + 3'd1;
         end
         if (grant_s) begin
            cur_ch_r    <= grant_ch_s;
            last_ch_r   <= grant_ch_s;
            sh_r        <= frame_s;
            rem_r       <= grant_ch_s ? LEN2 : LEN1;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
`ifdef CIC_READOUT_CHECKSUM_EN
            csum_r      <= hdr_s;
`endif
         end else if (hs_s && out_last_r) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            rem_r       <= 6'd0;
         end else if (hs_s) begin
            sh_r       <= sh_shift_s;
            rem_r      <= rem_r - 6'd1;
            out_last_r <= (rem_r == 6'd2);
`ifdef CIC_READOUT_CHECKSUM_EN
            csum_r     <= csum_r ^ sh_r[SW-9 -: 8];
`endif
         end else begin
            sh_r <= sh_r;
         end
      end
   end

   assign out_data_o  = sh_r[SW-1 -: 8];
   assign out_valid_o = out_valid_r;
   assign out_last_o  = out_last_r;
   assign ovf_o       = ovf_r;
   assign busy_o      = busy_r;
endmodule
